// File: rtl/multicycle_cpu.sv
// multicycle_cpu
//   Four-register, 16-bit-instruction multicycle CPU. Each instruction walks
//   FETCH -> DECODE -> EXEC (-> WB for ALU/addi) and returns to FETCH.
//   Fetching 16'hFFFF parks the machine in HALT until reset.
//
// Ports
//   clock      sole clock, rising edge
//   resetn     asynchronous active-low reset
//   imem_req   fetch request, high only while in FETCH and out of reset
//   imem_addr  fetch byte address, always equal to pc
//   imem_ack   fetch data valid; ignored outside FETCH
//   imem_data  fetched instruction
//   pc         program counter
//   ir         latched instruction
//   alu_out    registered last ALU result
//   halted     high in HALT
//   retired    retired-instruction counter (wraps)
//   state      FSM state: FETCH=0 DECODE=1 EXEC=2 WB=3 HALT=4
module multicycle_cpu #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 16
) (
    input  logic              clock,
    input  logic              resetn,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    output logic [PC_W-1:0]   pc,
    output logic [15:0]       ir,
    output logic [DATA_W-1:0] alu_out,
    output logic              halted,
    output logic [15:0]       retired,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_NOR  = 4'd4;
    localparam logic [3:0] OP_NAND = 4'd5;
    localparam logic [3:0] OP_SLT  = 4'd6;
    localparam logic [3:0] OP_ADDI = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;

    state_t            r_state;
    state_t            w_next_state;
    logic [PC_W-1:0]   r_pc;
    logic [15:0]       r_ir;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [15:0]       r_retired;
    // r_regs[0] is reset to zero and never written, so it always reads 0
    logic [DATA_W-1:0] r_regs [4];

    logic [3:0]        w_opcode;
    logic [1:0]        w_rs;
    logic [1:0]        w_rt;
    logic [1:0]        w_rd;
    logic [1:0]        w_dest;
    logic [DATA_W-1:0] w_simm;
    logic [PC_W-1:0]   w_br_off;
    logic [DATA_W-1:0] w_result;
    logic              w_is_alu;
    logic              w_is_branch;
    logic              w_taken;

    assign w_opcode    = r_ir[15:12];
    assign w_rs        = r_ir[11:10];
    assign w_rt        = r_ir[9:8];
    assign w_rd        = r_ir[7:6];
    assign w_dest      = (w_opcode == OP_ADDI) ? w_rt : w_rd;
    assign w_simm      = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
    // branch displacement counts halfwords: sign-extend imm, then shift left one
    assign w_br_off    = {{(PC_W-9){r_ir[7]}}, r_ir[7:0], 1'b0};
    assign w_is_alu    = (w_opcode <= OP_ADDI);
    assign w_is_branch = (w_opcode == OP_BEQ) || (w_opcode == OP_BNE);
    assign w_taken     = (w_opcode == OP_BEQ) ? (r_a == r_b) : (r_a != r_b);

    always_comb begin
        w_result = '0;
        case (w_opcode)
            OP_ADD:  w_result = r_a + r_b;
            OP_SUB:  w_result = r_a - r_b;
            OP_AND:  w_result = r_a & r_b;
            OP_OR:   w_result = r_a | r_b;
            OP_NOR:  w_result = ~(r_a | r_b);
            OP_NAND: w_result = ~(r_a & r_b);
            OP_SLT:  w_result = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_ADDI: w_result = r_a + w_simm;
            default: w_result = '0;
        endcase
    end

    // State register
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_FETCH:  if (imem_ack) w_next_state = S_DECODE;
            S_DECODE: w_next_state = (r_ir == 16'hFFFF) ? S_HALT : S_EXEC;
            S_EXEC:   w_next_state = w_is_alu ? S_WB : S_FETCH;
            S_WB:     w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // State-decoded outputs; the request is also gated by reset so it drops
    // immediately when resetn falls
    always_comb begin
        imem_req = resetn && (r_state == S_FETCH);
        halted   = (r_state == S_HALT);
    end

    // Datapath
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_alu     <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_retired <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_ir <= imem_data;
                        r_pc <= r_pc + PC_W'(2);
                    end
                end
                S_DECODE: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                end
                S_EXEC: begin
                    if (w_is_alu) begin
                        r_alu <= w_result;
                    end else begin
                        // branches and nops retire here; pc already points past the branch
                        if (w_is_branch) begin
                            r_alu <= r_a - r_b;
                            if (w_taken) r_pc <= r_pc + w_br_off;
                        end
                        r_retired <= r_retired + 16'd1;
                    end
                end
                S_WB: begin
                    if (w_dest != 2'd0) r_regs[w_dest] <= r_alu;
                    r_retired <= r_retired + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign ir        = r_ir;
    assign alu_out   = r_alu;
    assign retired   = r_retired;
    assign state     = r_state;

endmodule

// File: tb/tb_multicycle_cpu.sv
// Bench for multicycle_cpu: a 16-bit and a 32-bit instance, each driven in
// turn and checked against an instruction-level model of the ISA.
module tb_multicycle_cpu;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        rstn  [2];
    logic        ack   [2];
    logic [15:0] idata [2];

    logic        req    [2];
    logic [15:0] addr   [2];
    logic [15:0] pcw    [2];
    logic [15:0] irw    [2];
    logic        halt_w [2];
    logic [15:0] ret    [2];
    logic [2:0]  st     [2];
    logic [15:0] alu16;
    logic [31:0] alu32;
    logic [31:0] alu_obs [2];

    assign alu_obs[0] = {16'h0000, alu16};
    assign alu_obs[1] = alu32;

    multicycle_cpu #(.DATA_W(16), .PC_W(16)) dut16 (
        .clock(clock), .resetn(rstn[0]), .imem_req(req[0]), .imem_addr(addr[0]),
        .imem_ack(ack[0]), .imem_data(idata[0]), .pc(pcw[0]), .ir(irw[0]),
        .alu_out(alu16), .halted(halt_w[0]), .retired(ret[0]), .state(st[0])
    );

    multicycle_cpu #(.DATA_W(32), .PC_W(16)) dut32 (
        .clock(clock), .resetn(rstn[1]), .imem_req(req[1]), .imem_addr(addr[1]),
        .imem_ack(ack[1]), .imem_data(idata[1]), .pc(pcw[1]), .ir(irw[1]),
        .alu_out(alu32), .halted(halt_w[1]), .retired(ret[1]), .state(st[1])
    );

    // Architectural model, one per instance (index 0: 16-bit, 1: 32-bit)
    logic [31:0] mreg  [2][4];
    logic [15:0] mpc   [2];
    logic [15:0] mret  [2];
    logic [31:0] malu  [2];
    logic        mhalt [2];

    int checks = 0;
    int errors = 0;

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic model_reset(input int unsigned k);
        for (int unsigned r = 0; r < 4; r++) mreg[k][r] = '0;
        mpc[k]   = '0;
        mret[k]  = '0;
        malu[k]  = '0;
        mhalt[k] = 1'b0;
    endtask

    // Executes one instruction at ISA level; n = clock edges from DECODE to completion
    task automatic model_exec(input int unsigned k, input logic [15:0] ins, output int unsigned n);
        logic [31:0] mask, a, b, imm32, res;
        logic [3:0]  op;
        logic [1:0]  dest;
        int          sa, sb;
        mask  = (k == 0) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        op    = ins[15:12];
        a     = mreg[k][ins[11:10]];
        b     = mreg[k][ins[9:8]];
        imm32 = 32'($signed(ins[7:0])) & mask;
        sa    = (k == 0) ? int'($signed(a[15:0])) : int'($signed(a));
        sb    = (k == 0) ? int'($signed(b[15:0])) : int'($signed(b));
        res   = '0;
        if (ins == 16'hFFFF) begin
            mhalt[k] = 1'b1;
            n = 1;
        end else if (op <= 4'd7) begin
            case (op)
                4'd0: res = a + b;
                4'd1: res = a - b;
                4'd2: res = a & b;
                4'd3: res = a | b;
                4'd4: res = ~(a | b);
                4'd5: res = ~(a & b);
                4'd6: res = (sa < sb) ? 32'd1 : 32'd0;
                default: res = a + imm32;
            endcase
            res     = res & mask;
            malu[k] = res;
            dest    = (op == 4'd7) ? ins[9:8] : ins[7:6];
            if (dest != 2'd0) mreg[k][dest] = res;
            mret[k] = mret[k] + 16'd1;
            n = 3;
        end else if (op == 4'd10 || op == 4'd11) begin
            malu[k] = (a - b) & mask;
            if ((op == 4'd10) == (a == b))
                mpc[k] = 16'(int'(mpc[k]) + 2 * int'($signed(ins[7:0])));
            mret[k] = mret[k] + 16'd1;
            n = 2;
        end else begin
            mret[k] = mret[k] + 16'd1;
            n = 2;
        end
    endtask

    // Called just after a falling edge with the DUT in FETCH
    task automatic run_instr(input int unsigned k, input logic [15:0] ins, input int unsigned dly);
        int unsigned n;
        logic [2:0]  exp_st;
        for (int unsigned i = 0; i < dly; i++) begin
            ack[k]   = 1'b0;
            idata[k] = 16'($urandom);
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (st[k] !== 3'd0 || req[k] !== 1'b1 || addr[k] !== mpc[k]) begin
                errors++;
                $display("FAIL fetch_wait dut%0d: state=%0d req=%b addr=%h, expected state=0 req=1 addr=%h",
                         k, st[k], req[k], addr[k], mpc[k]);
            end
        end
        ack[k]   = 1'b1;
        idata[k] = ins;
        @(posedge clock);
        @(negedge clock);
        mpc[k] = mpc[k] + 16'd2;
        checks++;
        if (st[k] !== 3'd1 || irw[k] !== ins || pcw[k] !== mpc[k] || req[k] !== 1'b0) begin
            errors++;
            $display("FAIL fetch_latch dut%0d: state=%0d ir=%h pc=%h req=%b, expected state=1 ir=%h pc=%h req=0",
                     k, st[k], irw[k], pcw[k], req[k], ins, mpc[k]);
        end
        // noise on the fetch handshake while busy must have no effect
        ack[k]   = 1'($urandom);
        idata[k] = 16'($urandom);
        model_exec(k, ins, n);
        repeat (n) @(posedge clock);
        @(negedge clock);
        ack[k] = 1'b0;
        exp_st = mhalt[k] ? 3'd4 : 3'd0;
        checks++;
        if (st[k] !== exp_st || pcw[k] !== mpc[k] || ret[k] !== mret[k] || alu_obs[k] !== malu[k] ||
            halt_w[k] !== mhalt[k] || req[k] !== !mhalt[k]) begin
            errors++;
            $display("FAIL retire dut%0d ins=%h: state=%0d pc=%h ret=%0d alu=%h halted=%b req=%b, expected state=%0d pc=%h ret=%0d alu=%h halted=%b req=%b",
                     k, ins, st[k], pcw[k], ret[k], alu_obs[k], halt_w[k], req[k],
                     exp_st, mpc[k], mret[k], malu[k], mhalt[k], !mhalt[k]);
        end
    endtask

    // Called just after a falling edge; asserts reset at once, checks, releases
    task automatic reset_dut(input int unsigned k);
        rstn[k] = 1'b0;
        ack[k]  = 1'b0;
        #1;
        checks++;
        if (st[k] !== 3'd0 || pcw[k] !== 16'd0 || irw[k] !== 16'd0 || alu_obs[k] !== 32'd0 ||
            ret[k] !== 16'd0 || halt_w[k] !== 1'b0 || req[k] !== 1'b0 || addr[k] !== 16'd0) begin
            errors++;
            $display("FAIL reset_zero dut%0d: state=%0d pc=%h ir=%h alu=%h ret=%0d halted=%b req=%b addr=%h, expected all 0",
                     k, st[k], pcw[k], irw[k], alu_obs[k], ret[k], halt_w[k], req[k], addr[k]);
        end
        @(negedge clock);
        rstn[k] = 1'b1;
        model_reset(k);
    endtask

    task automatic test_reset();
        for (int unsigned k = 0; k < 2; k++) begin
            rstn[k]  = 1'b0;
            ack[k]   = 1'b0;
            idata[k] = 16'h0000;
            model_reset(k);
        end
        #2;
        for (int unsigned k = 0; k < 2; k++) begin
            checks++;
            if (st[k] !== 3'd0 || pcw[k] !== 16'd0 || irw[k] !== 16'd0 || alu_obs[k] !== 32'd0 ||
                ret[k] !== 16'd0 || halt_w[k] !== 1'b0 || req[k] !== 1'b0) begin
                errors++;
                $display("FAIL power_on_reset dut%0d: state=%0d pc=%h ir=%h alu=%h ret=%0d halted=%b req=%b, expected all 0",
                         k, st[k], pcw[k], irw[k], alu_obs[k], ret[k], halt_w[k], req[k]);
            end
        end
        @(negedge clock);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        for (int unsigned k = 0; k < 2; k++) begin
            checks++;
            if (st[k] !== 3'd0 || req[k] !== 1'b1 || addr[k] !== 16'd0) begin
                errors++;
                $display("FAIL first_fetch dut%0d: state=%0d req=%b addr=%h, expected state=0 req=1 addr=0",
                         k, st[k], req[k], addr[k]);
            end
        end
    endtask

    task automatic test_addi(input int unsigned k);
        run_instr(k, 16'h710F, 0);          // addi $1,$0,15
        checks++;
        if (alu_obs[k] !== 32'd15 || ret[k] !== 16'd1 || pcw[k] !== 16'd2) begin
            errors++;
            $display("FAIL addi_first dut%0d: alu=%h ret=%0d pc=%h, expected alu=f ret=1 pc=2",
                     k, alu_obs[k], ret[k], pcw[k]);
        end
        run_instr(k, 16'h3400, 0);          // or $0,$1,$0 reads reg1
        checks++;
        if (alu_obs[k] !== 32'd15) begin
            errors++;
            $display("FAIL addi_reg1 dut%0d: reg1=%h, expected f", k, alu_obs[k]);
        end
    endtask

    task automatic test_alu_vectors(input int unsigned k);
        logic [31:0] exp_sub, exp_add;
        exp_sub = (k == 0) ? 32'h0000_FFFE : 32'hFFFF_FFFE;
        exp_add = exp_sub;
        run_instr(k, 16'h71FF, 0);          // addi $1,$0,-1
        run_instr(k, 16'h7201, 0);          // addi $2,$0,1
        run_instr(k, 16'h66C0, 1);          // slt $3,$1,$2
        run_instr(k, 16'h3C00, 0);          // read reg3
        checks++;
        if (alu_obs[k] !== 32'd1) begin
            errors++;
            $display("FAIL slt_signed dut%0d: reg3=%h, expected 1", k, alu_obs[k]);
        end
        run_instr(k, 16'h16C0, 2);          // sub $3,$1,$2
        run_instr(k, 16'h3C00, 0);
        checks++;
        if (alu_obs[k] !== exp_sub) begin
            errors++;
            $display("FAIL sub_wrap dut%0d: reg3=%h, expected %h", k, alu_obs[k], exp_sub);
        end
        run_instr(k, 16'h0580, 0);          // add $2,$1,$1
        run_instr(k, 16'h3800, 0);          // read reg2
        checks++;
        if (alu_obs[k] !== exp_add) begin
            errors++;
            $display("FAIL add_wrap dut%0d: reg2=%h, expected %h", k, alu_obs[k], exp_add);
        end
        run_instr(k, 16'h70C0 | 16'h0005, 0); // addi $0,$0,5: write to reg0 dropped
        run_instr(k, 16'h3000, 0);          // read reg0
        checks++;
        if (alu_obs[k] !== 32'd0) begin
            errors++;
            $display("FAIL reg0_zero dut%0d: reg0=%h, expected 0", k, alu_obs[k]);
        end
    endtask

    task automatic test_branch(input int unsigned k);
        reset_dut(k);
        run_instr(k, 16'h7103, 0);          // addi $1,$0,3   pc -> 2
        run_instr(k, 16'h7205, 0);          // addi $2,$0,5   pc -> 4
        for (int unsigned i = 0; i < 9; i++) run_instr(k, 16'h8000, 0); // nops, pc -> 22
        run_instr(k, 16'hB6FC, 0);          // bne $1,$2,-4 taken
        checks++;
        if (pcw[k] !== 16'd16) begin
            errors++;
            $display("FAIL bne_taken dut%0d: pc=%h, expected 0010", k, pcw[k]);
        end
        run_instr(k, 16'h7203, 0);          // addi $2,$0,3   pc -> 18
        run_instr(k, 16'hC000, 0);          // nop            pc -> 20
        run_instr(k, 16'h9000, 0);          // nop            pc -> 22
        run_instr(k, 16'hB6FC, 0);          // bne not taken
        checks++;
        if (pcw[k] !== 16'd24) begin
            errors++;
            $display("FAIL bne_not_taken dut%0d: pc=%h, expected 0018", k, pcw[k]);
        end
        run_instr(k, 16'hA6FE, 0);          // beq $1,$2,-2 taken: 26-4 = 22
        run_instr(k, 16'hA001, 0);          // beq $0,$0,+1 taken
    endtask

    task automatic test_delay(input int unsigned k);
        run_instr(k, 16'h7D7F, 3);          // addi $1,$3,127 with 3-cycle fetch stall
        run_instr(k, 16'h4E40, 2);          // nor $1,$3,$2
        run_instr(k, 16'h5B80, 1);          // nand $2,$2,$3
    endtask

    task automatic test_random(input int unsigned k, input int unsigned count);
        logic [15:0] ins;
        for (int unsigned i = 0; i < count; i++) begin
            ins = 16'($urandom);
            if (ins == 16'hFFFF) ins = 16'h0000;
            run_instr(k, ins, $urandom_range(0, 2));
        end
    endtask

    task automatic test_halt(input int unsigned k);
        logic [15:0] pc_h, ret_h;
        run_instr(k, 16'hFFFF, 0);
        pc_h  = mpc[k];
        ret_h = mret[k];
        for (int unsigned i = 0; i < 4; i++) begin
            ack[k]   = 1'b1;
            idata[k] = 16'h7101;
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (st[k] !== 3'd4 || halt_w[k] !== 1'b1 || req[k] !== 1'b0 || pcw[k] !== pc_h || ret[k] !== ret_h) begin
                errors++;
                $display("FAIL halt_frozen dut%0d: state=%0d halted=%b req=%b pc=%h ret=%0d, expected state=4 halted=1 req=0 pc=%h ret=%0d",
                         k, st[k], halt_w[k], req[k], pcw[k], ret[k], pc_h, ret_h);
            end
        end
        ack[k] = 1'b0;
    endtask

    task automatic test_reset_mid_exec(input int unsigned k);
        reset_dut(k);
        ack[k]   = 1'b1;
        idata[k] = 16'h7105;                // addi $1,$0,5
        @(posedge clock);
        @(negedge clock);
        ack[k] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (st[k] !== 3'd2) begin
            errors++;
            $display("FAIL reach_exec dut%0d: state=%0d, expected 2", k, st[k]);
        end
        reset_dut(k);
        run_instr(k, 16'h3400, 0);          // reg1 must still be 0
        checks++;
        if (alu_obs[k] !== 32'd0) begin
            errors++;
            $display("FAIL aborted_write dut%0d: reg1=%h, expected 0", k, alu_obs[k]);
        end
    endtask

    initial begin
        test_reset();
        for (int unsigned k = 0; k < 2; k++) begin
            test_addi(k);
            test_alu_vectors(k);
            test_branch(k);
            test_delay(k);
            test_random(k, 60);
            test_halt(k);
            test_reset_mid_exec(k);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_cpu.md
MULTICYCLE_CPU -- requirements
Module: multicycle_cpu

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath and register width (legal: 16..32).
REQ-002 SHALL have parameter PC_W, default 16, program counter and instruction address width.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port imem_req  output  1  instruction fetch request.
REQ-006 SHALL have port imem_addr  output  PC_W  fetch byte address; always equals pc.
REQ-007 SHALL have port imem_ack  input  1  fetch data valid this cycle.
REQ-008 SHALL have port imem_data  input  16  fetched instruction.
REQ-009 SHALL have port pc  output  PC_W  current program counter.
REQ-010 SHALL have port ir  output  16  latched instruction.
REQ-011 SHALL have port alu_out  output  DATA_W  registered last ALU result.
REQ-012 SHALL have port halted  output  1  CPU stopped on halt instruction.
REQ-013 SHALL have port retired  output  16  count of retired instructions.
REQ-014 SHALL have port state  output  3  FSM state: FETCH=0, DECODE=1, EXEC=2, WB=3, HALT=4.

Function
REQ-015 SHALL hold 4 registers of DATA_W bits; reg 0 reads 0, writes to it discarded.
REQ-016 SHALL decode ir[15:12]: 0 add, 1 sub, 2 and, 3 or, 4 nor, 5 nand, 6 slt, 7 addi, 10 beq, 11 bne; 16'hFFFF halt; any other opcode is a nop.
REQ-017 SHALL use fields rs=ir[11:10], rt=ir[9:8], R-type rd=ir[7:6], addi dest=rt, imm=ir[7:0] sign-extended to DATA_W.
REQ-018 FETCH: imem_req=1 (combinational from state); on edge with imem_ack=1 -> ir<=imem_data, pc<=pc+2 (mod 2^PC_W), go DECODE; else stay, pc/imem_addr stable.
REQ-019 imem_ack while not in FETCH SHALL be ignored.
REQ-020 DECODE: latch operands A=reg[rs], B=reg[rt]; ir==16'hFFFF -> HALT, else EXEC.
REQ-021 EXEC, R-type/addi: alu_out<=result, go WB.
REQ-022 EXEC, beq/bne: alu_out<=A-B; if taken pc<=pc+(sext(imm,PC_W)<<1) mod 2^PC_W; retired+1; go FETCH.
REQ-023 EXEC, nop opcode: retired+1, go FETCH, no state change otherwise.
REQ-024 WB: reg[dest]<=alu_out unless dest==0; retired+1; go FETCH.
REQ-025 Arithmetic SHALL wrap mod 2^DATA_W; slt SHALL compare signed, result 1 or 0.
REQ-026 HALT: halted=1, absorbing until reset; pc, regs, retired frozen; imem_req=0.
REQ-027 Latency with imem_ack tied high: ALU/addi 4 cycles, branch/nop 3 cycles.
REQ-028 retired SHALL wrap 16'hFFFF -> 0.

Reset
REQ-029 resetn=0 SHALL immediately force: state FETCH, pc 0, ir 0, alu_out 0, all regs 0, retired 0, halted 0, imem_req 0.
REQ-030 Reset mid-fetch or mid-instruction SHALL abort it with no register write.
REQ-031 First rising edge after resetn deasserts SHALL be in FETCH with imem_req=1, imem_addr=0.

Verification
REQ-032 addi $1,$0,15 (0x710F), ack tied high -> after 4 cycles reg1=15, alu_out=15, retired=1, pc=2.
REQ-033 reg1=16'hFFFF, reg2=1, slt $3,$1,$2 -> reg3=1; sub $3,$1,$2 -> reg3=16'hFFFE.
REQ-034 bne $1,$2 imm 0xFC at pc=22, reg1!=reg2 -> pc=16 after 3 cycles; equal -> pc=24.
REQ-035 imem_ack delayed 3 cycles -> state FETCH for 4 cycles, imem_req=1 and imem_addr constant throughout.
REQ-036 0xFFFF fetched -> halted=1, state=4, pc and retired frozen; pulse resetn low mid-EXEC of prior instruction -> all outputs 0, no write.
REQ-037 DATA_W=32: addi $1,$0,-1 -> reg1=32'hFFFF_FFFF; add $2,$1,$1 -> 32'hFFFF_FFFE.
